// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: controller state encoding,
// indices of the CPOL/CPHA bits inside MODE, and the four SPI mode values.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for SCK: while enabled, raises tick for one PCLK cycle
// every DIV cycles. The count restarts from zero whenever it is disabled,
// so the first tick always lands DIV cycles after enable rises.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold at zero while disabled, wrap after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: full-duplex, MSB-first frames of DATA_W bits in any of the
// four CPOL/CPHA modes. A frame is requested with a START pulse while idle;
// SS falls on the accepting edge, SCK toggles every DIV cycles after a
// DIV-cycle lead-in, and a DIV-cycle trail precedes the DONE pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              MISO,
    output logic              SCK,
    output logic              SS,
    output logic              MOSI,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES);
    localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              sck_q, sck_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick;
    logic div_en;
    logic lead_edge;
    logic sample_edge;

    // The half-period timer runs for the whole frame and idles otherwise.
    assign div_en = (state_q != ST_IDLE);

    spi_clk_div #(
        .DIV (DIV)
    ) u_clk_div (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .enable (div_en),
        .tick   (tick)
    );

    // Even edge numbers leave the idle level (leading), odd ones return to it.
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign lead_edge   = ~edge_q[0];
    assign sample_edge = (lead_edge != mode_q[CPHA_BIT]);

    // Next-state and datapath decode for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        sck_d     = sck_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Idle SCK tracks the requested polarity so the line is
                // already at rest level when SS falls.
                sck_d = MODE[CPOL_BIT];
                if (START) begin
                    mode_d  = MODE;
                    tx_d    = TX_DATA;
                    rx_sh_d = '0;
                    edge_d  = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = TX_DATA[DATA_W-1];
                    state_d = ST_LEAD;
                end
            end

            ST_LEAD, ST_XFER: begin
                // The tick that ends the lead-in is itself SCK edge 0.
                if (state_q == ST_LEAD) begin
                    sck_d = mode_q[CPOL_BIT];
                end
                if (tick) begin
                    sck_d = ~sck_q;
                    if (sample_edge) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
                    end else if (mode_q[CPHA_BIT]) begin
                        // First leading edge re-presents the MSB already on MOSI.
                        if (edge_q != '0) begin
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[DATA_W-2];
                        end
                    end else begin
                        // Final trailing edge leaves the last bit in place.
                        if (edge_q != LAST_EDGE) begin
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[DATA_W-2];
                        end
                    end

                    if (edge_q == LAST_EDGE) begin
                        sck_d   = mode_q[CPOL_BIT];
                        edge_d  = '0;
                        state_d = ST_TRAIL;
                    end else begin
                        edge_d  = edge_q + 1'b1;
                        state_d = ST_XFER;
                    end
                end
            end

            ST_TRAIL: begin
                sck_d = mode_q[CPOL_BIT];
                if (tick) begin
                    ss_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'b00;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            sck_q     <= sck_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SCK     = sck_q;
    assign SS      = ss_q;
    assign MOSI    = mosi_q;
    assign RX_DATA = rx_data_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an 8-bit/DIV=4 build and a 16-bit/DIV=1 build, driven
// by random frames and checked against a protocol-level SPI slave model.
`timescale 1ns/1ps
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        preset = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic        miso = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] tx = 16'h0;

    logic        sck8, ss8, mosi8, busy8, done8;
    logic [7:0]  rx8;
    logic        sck16, ss16, mosi16, busy16, done16;
    logic [15:0] rx16;

    spi_master #(.DATA_W(8), .DIV(4)) dut8 (
        .PCLK(clk), .PRESET(preset), .START(start8), .MODE(mode),
        .TX_DATA(tx[7:0]), .MISO(miso), .SCK(sck8), .SS(ss8), .MOSI(mosi8),
        .RX_DATA(rx8), .BUSY(busy8), .DONE(done8)
    );

    spi_master #(.DATA_W(16), .DIV(1)) dut16 (
        .PCLK(clk), .PRESET(preset), .START(start16), .MODE(mode),
        .TX_DATA(tx), .MISO(miso), .SCK(sck16), .SS(ss16), .MOSI(mosi16),
        .RX_DATA(rx16), .BUSY(busy16), .DONE(done16)
    );

    // Selected DUT view
    logic        sel16 = 1'b0;
    logic        sck_w, ss_w, mosi_w, busy_w, done_w;
    logic [15:0] rx_w;
    assign sck_w  = sel16 ? sck16  : sck8;
    assign ss_w   = sel16 ? ss16   : ss8;
    assign mosi_w = sel16 ? mosi16 : mosi8;
    assign busy_w = sel16 ? busy16 : busy8;
    assign done_w = sel16 ? done16 : done8;
    assign rx_w   = sel16 ? rx16   : {8'h00, rx8};

    int checks = 0;
    int failures = 0;

    // Edge index: incremented at each rising edge before registers update.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural SPI slave: presents slv_tx MSB-first, captures MOSI,
    // records how many SCK edges it saw and when the first/last occurred.
    int          slv_w = 8;
    logic [1:0]  slv_mode = 2'b00;
    logic [15:0] slv_tx = 16'h0;
    logic [15:0] slv_rx = 16'h0;
    int          slv_idx = 0;
    int          slv_edges = 0;
    int          slv_first = 0;
    int          slv_last = 0;
    logic        slv_lead;

    always @(negedge ss_w) begin
        slv_rx    = 16'h0;
        slv_edges = 0;
        slv_idx   = slv_w - 1;
        if (!slv_mode[0]) begin
            miso = slv_tx[slv_idx];
            slv_idx--;
        end
    end

    always @(sck_w) begin
        if (ss_w == 1'b0) begin
            slv_lead = (sck_w != slv_mode[1]);
            if (slv_edges == 0) slv_first = cyc;
            slv_last = cyc;
            slv_edges++;
            if (slv_lead != slv_mode[0]) begin
                slv_rx = {slv_rx[14:0], mosi_w};
            end else if (slv_idx >= 0) begin
                miso = slv_tx[slv_idx];
                slv_idx--;
            end
        end
    end

    // One frame on the selected DUT with full protocol and timing checks.
    task automatic run_frame(input bit s16, input logic [1:0] m,
                             input logic [15:0] t, input logic [15:0] sd,
                             input string name);
        int w, dv, lat_exp, n, start_edge;
        bit got;
        logic [15:0] mask;
        w       = s16 ? 16 : 8;
        dv      = s16 ? 1 : 4;
        lat_exp = 1 + dv * (2 * w + 1);
        mask    = s16 ? 16'hFFFF : 16'h00FF;
        sel16 = s16; slv_w = w; slv_mode = m; slv_tx = sd & mask;
        mode = m; tx = t;
        repeat (2) @(negedge clk);
        checks++;
        if (sck_w !== m[1]) begin
            failures++;
            $display("FAIL %s idle_sck: got %b expected %b", name, sck_w, m[1]);
        end
        start_edge = cyc + 1;
        if (s16) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        n = 1; got = 1'b0;
        while (n < 3000) begin
            if (done_w === 1'b1) begin
                got = 1'b1;
                break;
            end
            // Inputs changing mid-frame must be ignored.
            tx = 16'($urandom);
            mode = 2'($urandom);
            if (s16) start16 = ($urandom_range(0, 3) == 0);
            else     start8  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        start8 = 1'b0; start16 = 1'b0;
        if (!got) $display("FAIL %s done_timeout: got none expected DONE", name);
        checks++;
        if (n != lat_exp) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, lat_exp);
        end
        checks++;
        if (ss_w !== 1'b1 || busy_w !== 1'b0) begin
            failures++;
            $display("FAIL %s ss_busy_at_done: got ss=%b busy=%b expected ss=1 busy=0", name, ss_w, busy_w);
        end
        checks++;
        if (rx_w !== (sd & mask)) begin
            failures++;
            $display("FAIL %s rx_data: got %h expected %h", name, rx_w, sd & mask);
        end
        checks++;
        if ((slv_rx & mask) !== (t & mask)) begin
            failures++;
            $display("FAIL %s mosi_bits: got %h expected %h", name, slv_rx & mask, t & mask);
        end
        checks++;
        if (slv_edges != 2 * w) begin
            failures++;
            $display("FAIL %s sck_edges: got %0d expected %0d", name, slv_edges, 2 * w);
        end
        checks++;
        if (slv_first != start_edge + dv || slv_last != start_edge + 2 * w * dv) begin
            failures++;
            $display("FAIL %s edge_timing: got first=%0d last=%0d expected first=%0d last=%0d",
                     name, slv_first - start_edge, slv_last - start_edge, dv, 2 * w * dv);
        end
        checks++;
        if (sck_w !== m[1]) begin
            failures++;
            $display("FAIL %s sck_rest: got %b expected %b", name, sck_w, m[1]);
        end
        @(negedge clk);
        checks++;
        if (done_w !== 1'b0 || busy_w !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: got done=%b busy=%b expected done=0 busy=0", name, done_w, busy_w);
        end
        $display("frame %s mode=%0d tx=%h slave=%h rx=%h latency=%0d", name, m, t & mask, sd & mask, rx_w, n);
    endtask

    task automatic test_reset();
        preset = 1'b1; mode = 2'b11; start8 = 1'b0; start16 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sck8, ss8, mosi8, busy8, done8} !== 5'b01000 || rx8 !== 8'h00) begin
            failures++;
            $display("FAIL reset8: got sck=%b ss=%b mosi=%b busy=%b done=%b rx=%h expected 0 1 0 0 0 00",
                     sck8, ss8, mosi8, busy8, done8, rx8);
        end
        checks++;
        if ({sck16, ss16, mosi16, busy16, done16} !== 5'b01000 || rx16 !== 16'h0000) begin
            failures++;
            $display("FAIL reset16: got sck=%b ss=%b mosi=%b busy=%b done=%b rx=%h expected 0 1 0 0 0 0000",
                     sck16, ss16, mosi16, busy16, done16, rx16);
        end
        preset = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_mode0_basic();
        run_frame(1'b0, 2'b00, 16'h00A5, 16'h003C, "mode0_a5");
    endtask

    task automatic test_modes();
        run_frame(1'b0, 2'b01, 16'h00C3, 16'h005A, "mode1_c3");
        run_frame(1'b0, 2'b10, 16'h00C3, 16'h005A, "mode2_c3");
        run_frame(1'b0, 2'b11, 16'h00C3, 16'h005A, "mode3_c3");
        for (int i = 0; i < 6; i++) begin
            run_frame(1'b0, 2'($urandom), 16'($urandom), 16'($urandom), "random8");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tv [3];
        logic [15:0] sv [3];
        logic [1:0]  m;
        int n, dones, extra;
        bit got;
        m = 2'($urandom);
        for (int i = 0; i < 3; i++) begin
            tv[i] = 16'($urandom_range(0, 255));
            sv[i] = 16'($urandom_range(1, 255));
        end
        sel16 = 1'b0; slv_w = 8; slv_mode = m; slv_tx = sv[0];
        mode = m; tx = tv[0];
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        dones = 0;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            n = 1;
            checks++;
            if (ss_w !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ss_low frame%0d: got %b expected 0", f, ss_w);
            end
            got = 1'b0;
            while (n < 3000) begin
                if (done_w === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                tx = 16'($urandom);
                mode = 2'($urandom);
                @(negedge clk);
                n++;
            end
            if (got) dones++;
            checks++;
            if (n != 69) begin
                failures++;
                $display("FAIL b2b_latency frame%0d: got %0d expected 69", f, n);
            end
            checks++;
            if (rx_w !== sv[f] || slv_rx[7:0] !== tv[f][7:0]) begin
                failures++;
                $display("FAIL b2b_data frame%0d: got rx=%h mosi=%h expected rx=%h mosi=%h",
                         f, rx_w, slv_rx[7:0], sv[f], tv[f][7:0]);
            end
            $display("b2b frame%0d tx=%h slave=%h rx=%h latency=%0d", f, tv[f][7:0], sv[f], rx_w, n);
            mode = m;
            if (f < 2) begin
                tx = tv[f + 1];
                slv_tx = sv[f + 1];
            end else begin
                start8 = 1'b0;
            end
        end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_w === 1'b1 || ss_w !== 1'b1) extra++;
        end
        checks++;
        if (dones != 3 || extra != 0) begin
            failures++;
            $display("FAIL b2b_count: got dones=%0d extra_activity=%0d expected dones=3 extra_activity=0", dones, extra);
        end
    endtask

    task automatic test_reset_midframe();
        int n, bad;
        sel16 = 1'b0; slv_w = 8; slv_mode = 2'b11; slv_tx = 16'h00E7;
        mode = 2'b11; tx = 16'($urandom);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (slv_edges < 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (slv_edges != 8) begin
            failures++;
            $display("FAIL midreset_reach_edge7: got edges=%0d expected 8", slv_edges);
        end
        preset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sck8, ss8, mosi8, busy8, done8} !== 5'b01000 || rx8 !== 8'h00) begin
            failures++;
            $display("FAIL midreset_state: got sck=%b ss=%b mosi=%b busy=%b done=%b rx=%h expected 0 1 0 0 0 00",
                     sck8, ss8, mosi8, busy8, done8, rx8);
        end
        preset = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
        end
        $display("mid-frame reset checked");
        run_frame(1'b0, 2'($urandom), 16'($urandom), 16'($urandom), "after_reset");
    endtask

    task automatic test_div1_w16();
        run_frame(1'b1, 2'b00, 16'h8001, 16'($urandom), "w16_8001");
        run_frame(1'b1, 2'($urandom), 16'($urandom), 16'($urandom), "w16_rand_a");
        run_frame(1'b1, 2'($urandom), 16'($urandom), 16'($urandom), "w16_rand_b");
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_modes();
        test_back_to_back();
        test_reset_midframe();
        test_div1_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that drives SCK, SS and MOSI, and samples MISO; the counterpart of the existing SPI_SLAVE block.
- Full-duplex, MSB-first frames of DATA_W bits, supporting all four CPOL/CPHA modes.
- Controlled from the local PCLK domain by a single-cycle START / BUSY / DONE handshake.
- Sits between the control logic and the off-block SPI pins.

Parameters:
DATA_W, 8, frame length in bits (>=2)
DIV, 4, SCK half-period in PCLK cycles (>=1)

Ports:
PCLK  input  1  system clock, all logic on rising edge
PRESET  input  1  synchronous reset, active-high
START  input  1  request a frame; sampled only while idle
MODE  input  2  [1]=CPOL, [0]=CPHA; latched on accepted START
TX_DATA  input  DATA_W  frame to send; latched on accepted START
MISO  input  1  serial data from slave
SCK  output  1  serial clock (registered)
SS  output  1  slave select, active-low (registered)
MOSI  output  1  serial data to slave (registered)
RX_DATA  output  DATA_W  last received frame, held until next DONE
BUSY  output  1  high from SS fall through TRAIL end
DONE  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: SCK=0, SS=1, MOSI=0, RX_DATA=0, BUSY=0, DONE=0; state=IDLE; latched mode=0; all counters=0. Reset mid-frame aborts immediately: no DONE, RX_DATA is cleared.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- IDLE:
  - SCK follows MODE[1] each cycle (registered).
  - START=1 at edge k: latch MODE and TX_DATA; at k+1 SS=0, BUSY=1, MOSI=TX_DATA[DATA_W-1]; enter LEAD.
- LEAD: lasts DIV cycles. SCK holds CPOL.
- XFER:
  - 2*DATA_W SCK edges; edge n (n=0..2*DATA_W-1) occurs at k+1+DIV*(n+1).
  - Even n is the leading edge; odd n is the trailing edge.
  - CPHA=0: sample MISO on leading edges, shift MOSI to the next bit on trailing edges. The final trailing edge does not shift.
  - CPHA=1: shift MOSI on leading edges (the first leading edge drives TX_DATA[DATA_W-1]), sample on trailing edges. Under CPHA=1, MOSI at SS fall is TX_DATA[DATA_W-1].
  - Sampling shifts the sampled bit into an internal shift register at the LSB.
  - After the last edge, SCK=CPOL; enter TRAIL.
- TRAIL: lasts DIV cycles. Then SS=1, BUSY=0, DONE=1, RX_DATA updated, all in the same cycle; state returns to IDLE.
- Latency: DONE asserts exactly 1+DIV*(2*DATA_W+1) cycles after the START sample edge (DATA_W=8, DIV=4: 69 cycles).
- The DONE cycle is IDLE, so START asserted in the DONE cycle is accepted: back-to-back frames with SS high for exactly 1 cycle.
- START while BUSY is ignored, with no queuing. MODE and TX_DATA changes while BUSY have no effect.
- MOSI is held after the last bit until the next frame; it is only cleared by reset.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, LEAD, XFER, TRAIL; 2 bits)
  - CPOL_BIT=1, CPHA_BIT=0 indices
  - mode constants MODE0..MODE3
- Sub-module spi_clk_div:
  - inputs: PCLK, PRESET, enable
  - output: one-cycle half-period tick every DIV cycles while enabled
  - counter clears when disabled

Test Plan:
- Reset, then MODE=00, TX_DATA=8'hA5, START pulse, slave model returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1 sampled on SCK rises; RX_DATA=8'h3C; DONE at START+69 cycles; SS high in the DONE cycle.
- Modes 01, 10 and 11 with TX=8'hC3, slave returns 8'h5A -> correct idle SCK level per CPOL, correct edge alignment per CPHA, RX_DATA=8'h5A in all modes.
- START held high continuously for 3 frames -> SS high exactly 1 cycle between frames; START pulses during BUSY are ignored; exactly 3 DONE pulses.
- PRESET asserted on edge 7 of a frame -> next cycle SCK=0, SS=1, BUSY=0, RX_DATA=0, no DONE; the next START completes a normal frame.
- DIV=1, DATA_W=16 build, TX=16'h8001 -> 16 full SCK periods, DONE at START+34 cycles, RX matches the slave model.
